// File: rtl/irrigation_timer_pkg.sv
// irrigation_timer_pkg: shared state type, limits and BCD helpers for the irrigation timer
package irrigation_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;
  localparam int MAX_SECONDS = 99;
  localparam int DIGIT_W = 4;
  function automatic logic [2*DIGIT_W-1:0] to_bcd(input logic [7:0] bin);
    logic [7:0] r;
    logic [DIGIT_W-1:0] t;
    r = bin > 8'(MAX_SECONDS) ? 8'(MAX_SECONDS) : bin;
    t = '0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 8'd10) begin
        r = r - 8'd10;
        t = t + 1'b1;
      end
    end
    return {t, r[DIGIT_W-1:0]};
  endfunction
  function automatic logic [2*DIGIT_W-1:0] bcd_dec(input logic [2*DIGIT_W-1:0] v);
    return v[DIGIT_W-1:0] == '0 ? {v[2*DIGIT_W-1:DIGIT_W] - 1'b1, DIGIT_W'(9)}
                                : {v[2*DIGIT_W-1:DIGIT_W], v[DIGIT_W-1:0] - 1'b1};
  endfunction
endpackage

// File: rtl/irrigation_timer_if.sv
// irrigation_timer_if: control and status bundle between the irrigation controller and the timer
interface irrigation_timer_if;
  logic start;
  logic abort;
  logic [7:0] duration;
  logic valve;
  logic busy;
  logic done;
  logic fault;
  logic [7:0] remaining_bcd;
  modport master(output start, abort, duration, input valve, busy, done, fault, remaining_bcd);
  modport slave(input start, abort, duration, output valve, busy, done, fault, remaining_bcd);
endinterface

// File: rtl/irrigation_timer_tick_sync.sv
// tick_sync: two-flop synchronizer with rising-edge pulse for a slow asynchronous tick
module tick_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);
  logic s1, s2, prev;
  always_ff @(posedge clock) begin
    if (!reset_n) {s1, s2, prev} <= '0;
    else {s1, s2, prev} <= {async_in, s1, s2};
  end
  assign pulse = s2 & ~prev;
endmodule

// File: rtl/irrigation_timer.sv
// irrigation_timer: counts a BCD valve-open interval down on the 1 Hz tick, with stall watchdog
module irrigation_timer
  import irrigation_timer_pkg::*;
#(
  parameter int WDOG_CYCLES = 100_000_000,
  parameter int WDOG_W = 27
) (
  input logic clock,
  input logic reset_n,
  input logic tick_in,
  irrigation_timer_if.slave bus
);
  logic tick;
  state_t state, state_n;
  logic [2*DIGIT_W-1:0] rem, rem_n, load;
  logic [WDOG_W-1:0] wdog, wdog_n;
  logic expired;
  tick_sync u_sync (
    .clock(clock),
    .reset_n(reset_n),
    .async_in(tick_in),
    .pulse(tick)
  );
  assign load = to_bcd(bus.duration);
  assign expired = wdog == WDOG_W'(WDOG_CYCLES - 1);
  // abort beats tick, and tick beats watchdog expiry
  always_comb begin
    state_n = state;
    rem_n = rem;
    wdog_n = '0;
    case (state)
      IDLE: if (bus.start && !bus.abort) begin
        rem_n = load;
        state_n = load == '0 ? DONE : RUN;
      end
      RUN: if (bus.abort) state_n = IDLE;
      else if (tick) begin
        rem_n = bcd_dec(rem);
        state_n = rem == 8'h01 ? DONE : RUN;
      end
      else if (expired) state_n = FAULT;
      else wdog_n = wdog + 1'b1;
      DONE: state_n = IDLE;
      FAULT: state_n = bus.abort ? IDLE : FAULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      rem <= '0;
      wdog <= '0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      wdog <= wdog_n;
    end
  end
  assign bus.valve = state == RUN;
  assign bus.busy = state == RUN || state == FAULT;
  assign bus.done = state == DONE;
  assign bus.fault = state == FAULT;
  assign bus.remaining_bcd = rem;
endmodule

// File: tb/tb_irrigation_timer.sv
// tb_irrigation_timer: directed self-checking bench for irrigation_timer
module tb_irrigation_timer;
  logic clock = 1'b0;
  logic reset_n;
  logic tick_in;
  int vectors = 0;
  int errs = 0;
  irrigation_timer_if bus ();
  irrigation_timer #(.WDOG_CYCLES(1000), .WDOG_W(10)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .tick_in(tick_in),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pulse_tick;
    tick_in = 1'b1;
    cyc(3);
    tick_in = 1'b0;
    cyc(3);
  endtask
  task automatic go(input logic [7:0] d);
    bus.duration = d;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0;
    tick_in = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.duration = 8'd0;
    cyc(2);
    chk("rst_rem", bus.remaining_bcd, 8'h00);
    chk("rst_valve", 8'(bus.valve), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_fault", 8'(bus.fault), 8'd0);
    reset_n = 1'b1;
    cyc(1);
    go(8'd3);
    chk("run_load", bus.remaining_bcd, 8'h03);
    chk("run_valve", 8'(bus.valve), 8'd1);
    chk("run_busy", 8'(bus.busy), 8'd1);
    tick_in = 1'b1;
    cyc(2);
    chk("run_lat2", bus.remaining_bcd, 8'h03);
    cyc(1);
    chk("run_t1", bus.remaining_bcd, 8'h02);
    tick_in = 1'b0;
    cyc(197);
    tick_in = 1'b1;
    cyc(3);
    chk("run_t2", bus.remaining_bcd, 8'h01);
    tick_in = 1'b0;
    cyc(197);
    tick_in = 1'b1;
    cyc(2);
    chk("run_pre_valve", 8'(bus.valve), 8'd1);
    chk("run_pre_done", 8'(bus.done), 8'd0);
    cyc(1);
    chk("run_t3", bus.remaining_bcd, 8'h00);
    chk("run_end_valve", 8'(bus.valve), 8'd0);
    chk("run_end_done", 8'(bus.done), 8'd1);
    cyc(1);
    chk("run_done_1cyc", 8'(bus.done), 8'd0);
    chk("run_idle_busy", 8'(bus.busy), 8'd0);
    tick_in = 1'b0;
    cyc(4);
    go(8'd150);
    chk("clamp_load", bus.remaining_bcd, 8'h99);
    repeat (10) pulse_tick();
    chk("borrow_89", bus.remaining_bcd, 8'h89);
    repeat (79) pulse_tick();
    chk("borrow_10", bus.remaining_bcd, 8'h10);
    repeat (9) pulse_tick();
    chk("borrow_01", bus.remaining_bcd, 8'h01);
    chk("borrow_valve", 8'(bus.valve), 8'd1);
    tick_in = 1'b1;
    cyc(2);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    tick_in = 1'b0;
    chk("race_done", 8'(bus.done), 8'd0);
    chk("race_valve", 8'(bus.valve), 8'd0);
    chk("race_busy", 8'(bus.busy), 8'd0);
    chk("race_rem", bus.remaining_bcd, 8'h01);
    cyc(3);
    chk("race_done_late", 8'(bus.done), 8'd0);
    bus.abort = 1'b1;
    go(8'd5);
    bus.abort = 1'b0;
    chk("sa_busy", 8'(bus.busy), 8'd0);
    chk("sa_rem", bus.remaining_bcd, 8'h01);
    go(8'd0);
    chk("zero_done", 8'(bus.done), 8'd1);
    chk("zero_valve", 8'(bus.valve), 8'd0);
    chk("zero_rem", bus.remaining_bcd, 8'h00);
    cyc(1);
    chk("zero_done_1cyc", 8'(bus.done), 8'd0);
    chk("zero_valve2", 8'(bus.valve), 8'd0);
    go(8'd5);
    chk("wd_valve", 8'(bus.valve), 8'd1);
    cyc(999);
    chk("wd_999_fault", 8'(bus.fault), 8'd0);
    chk("wd_999_valve", 8'(bus.valve), 8'd1);
    cyc(1);
    chk("wd_fault", 8'(bus.fault), 8'd1);
    chk("wd_valve_off", 8'(bus.valve), 8'd0);
    chk("wd_busy", 8'(bus.busy), 8'd1);
    go(8'd7);
    chk("wd_start_ign", 8'(bus.fault), 8'd1);
    chk("wd_start_rem", bus.remaining_bcd, 8'h05);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    chk("wd_abort_fault", 8'(bus.fault), 8'd0);
    chk("wd_abort_busy", 8'(bus.busy), 8'd0);
    go(8'd5);
    pulse_tick();
    pulse_tick();
    chk("mr_rem", bus.remaining_bcd, 8'h03);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk("mr_valve", 8'(bus.valve), 8'd0);
    chk("mr_busy", 8'(bus.busy), 8'd0);
    chk("mr_rem0", bus.remaining_bcd, 8'h00);
    chk("mr_done", 8'(bus.done), 8'd0);
    go(8'd2);
    chk("mr_restart", bus.remaining_bcd, 8'h02);
    chk("mr_restart_valve", 8'(bus.valve), 8'd1);
    pulse_tick();
    tick_in = 1'b1;
    cyc(3);
    chk("mr_final_done", 8'(bus.done), 8'd1);
    chk("mr_final_rem", bus.remaining_bcd, 8'h00);
    tick_in = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
